// File: rtl/tm1638_key_events.sv
// tm1638_key_events: synchronises and debounces the TM1638 key vector, turns
// debounced edges into press/release events and queues them in a small FIFO
// with a valid/ready interface. Loss of an event is flagged by a sticky bit.
module tm1638_key_events #(
  parameter int w_keys     = 8,
  parameter int db_cycles  = 250000,
  parameter int fifo_depth = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [w_keys-1:0] keys,
  output logic [w_keys-1:0] key_state,
  output logic [w_keys-1:0] press_pulse,
  output logic [w_keys-1:0] release_pulse,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [3:0]        ev_code,
  output logic [2:0]        ev_count,
  output logic              overflow,
  input  logic              overflow_clr
);

  // Counter wide enough to reach db_cycles-1; pointer width for the FIFO.
  // The 3-bit occupancy port limits fifo_depth to 2 or 4.
  localparam int CW = $clog2(db_cycles);
  localparam int PW = $clog2(fifo_depth);

  logic [w_keys-1:0]         sync1_q, sync1_d;
  logic [w_keys-1:0]         sync2_q, sync2_d;
  logic [w_keys-1:0]         stable_q, stable_d;
  logic [w_keys-1:0][CW-1:0] cnt_q, cnt_d;
  logic [w_keys-1:0]         press_q, press_d;
  logic [w_keys-1:0]         rel_q, rel_d;
  logic [w_keys-1:0]         pend_p_q, pend_p_d;
  logic [w_keys-1:0]         pend_r_q, pend_r_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [2:0]                count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [3:0]                mem_q [fifo_depth];

  logic              sel_found;
  logic              sel_type;
  logic [2:0]        sel_idx;
  logic              push;
  logic              pop;
  logic              loss;
  logic [3:0]        ev_wr_d;
  logic [w_keys-1:0] clr_p;
  logic [w_keys-1:0] clr_r;

  // Two-flop synchroniser and per-key debounce counters with edge detection.
  always_comb begin
    sync1_d  = keys;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < w_keys; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(db_cycles - 1)) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d = stable_d & ~stable_q;
    rel_d   = ~stable_d & stable_q;
  end

  // Arbiter, pending bookkeeping, FIFO pointers and overflow tracking.
  always_comb begin
    sel_found = 1'b0;
    sel_type  = 1'b0;
    sel_idx   = 3'd0;
    // Scan from the top so the lowest pending key index wins; press beats
    // release within a key.
    for (int i = w_keys - 1; i >= 0; i--) begin
      if (pend_p_q[i] || pend_r_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_type  = pend_p_q[i];
      end
    end
    // A same-cycle pop does not free a slot for the push.
    push    = sel_found && (count_q != 3'(fifo_depth));
    pop     = (count_q != 3'd0) && ev_ready;
    ev_wr_d = {sel_type, sel_idx};
    clr_p   = '0;
    clr_r   = '0;
    if (push) begin
      if (sel_type) clr_p[sel_idx] = 1'b1;
      else          clr_r[sel_idx] = 1'b1;
    end
    // A new pulse on a bit that is being pushed this cycle is not a loss.
    loss     = |(press_q & pend_p_q & ~clr_p) || |(rel_q & pend_r_q & ~clr_r);
    pend_p_d = (pend_p_q & ~clr_p) | press_q;
    pend_r_d = (pend_r_q & ~clr_r) | rel_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    if (loss) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      pend_p_q <= '0;
      pend_r_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      pend_p_q <= pend_p_d;
      pend_r_q <= pend_r_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are masked by the occupancy count so no reset.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= ev_wr_d;
    end
  end

  assign key_state     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign ev_valid      = (count_q != 3'd0);
  assign ev_code       = (count_q != 3'd0) ? mem_q[rd_ptr_q] : 4'h0;
  assign ev_count      = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_tm1638_key_events.sv
// Testbench for tm1638_key_events: directed scenarios plus a randomized phase,
// all checked every cycle against an event-level reference model.
module tb_tm1638_key_events;

  localparam int DB = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] keys = 8'h00;
  logic       ev_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] key_state, press_pulse, release_pulse;
  logic       ev_valid, overflow;
  logic [3:0] ev_code;
  logic [2:0] ev_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tm1638_key_events #(.w_keys(8), .db_cycles(DB), .fifo_depth(FD)) dut (
    .clk(clk), .rst(rst), .keys(keys),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_count(ev_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  // Reference model: raw keys pass a 2-sample delay line; a key's stable level
  // flips once the last DB synchronised samples all disagree with it.
  logic [7:0] m_k1, m_k2, m_stable, m_pp, m_rp, m_pend_p, m_pend_r;
  logic [7:0] m_win [DB];
  logic [3:0] m_q [$];
  logic       m_ovf;
  bit         m_started = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] s, flip, newst, clrp, clrr;
    logic [3:0] code;
    bit pop, push, found, loss;
    if (!rst) begin
      m_k1 = '0; m_k2 = '0; m_stable = '0; m_pp = '0; m_rp = '0;
      m_pend_p = '0; m_pend_r = '0; m_ovf = 1'b0;
      for (int j = 0; j < DB; j++) m_win[j] = '0;
      m_q.delete();
      m_started = 1'b1;
    end else begin
      pop   = (m_q.size() != 0) && ev_ready;
      found = 1'b0;
      code  = 4'h0;
      for (int i = 0; i < 8 && !found; i++) begin
        if (m_pend_p[i]) begin found = 1'b1; code = {1'b1, 3'(i)}; end
        else if (m_pend_r[i]) begin found = 1'b1; code = {1'b0, 3'(i)}; end
      end
      push = found && (m_q.size() < FD);
      clrp = '0;
      clrr = '0;
      if (push) begin
        if (code[3]) clrp[code[2:0]] = 1'b1;
        else         clrr[code[2:0]] = 1'b1;
      end
      loss = (|(m_pp & m_pend_p & ~clrp)) || (|(m_rp & m_pend_r & ~clrr));
      m_pend_p = (m_pend_p & ~clrp) | m_pp;
      m_pend_r = (m_pend_r & ~clrr) | m_rp;
      if (loss) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(code);
      s = m_k2;
      m_k2 = m_k1;
      m_k1 = keys;
      for (int j = DB - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = s;
      flip = 8'hFF;
      for (int j = 0; j < DB; j++) flip = flip & (m_win[j] ^ m_stable);
      newst    = m_stable ^ flip;
      m_pp     = newst & ~m_stable;
      m_rp     = m_stable & ~newst;
      m_stable = newst;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [32:0] exp_v, act_v;
    if (m_started) begin
      exp_v = {m_stable, m_pp, m_rp, (m_q.size() != 0),
               (m_q.size() != 0) ? m_q[0] : 4'h0, 3'(m_q.size()), m_ovf};
      act_v = {key_state, press_pulse, release_pulse, ev_valid,
               ev_code, ev_count, overflow};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Accept n events with ev_ready high; seq holds the codes, first in low nibble.
  task automatic expect_events(input string name, input logic [31:0] seq, input int n);
    int w;
    ev_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!ev_valid && w < 40) begin
        tick(1);
        w++;
      end
      check(name, {27'd0, ev_valid, ev_code}, {27'd0, 1'b1, seq[4*k +: 4]});
      tick(1);
    end
    ev_ready = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // 1: all keys held through reset
    rst = 1'b0; keys = 8'hFF; ev_ready = 1'b0; overflow_clr = 1'b0;
    tick(3);
    check("reset_outputs", {key_state, press_pulse, release_pulse, 4'(ev_valid), ev_code},
          32'h0);
    check("reset_count_ovf", {ev_count, overflow}, 32'h0);
    rst = 1'b1;
    tick(5);
    check("latency_before", key_state, 32'h00);
    tick(1);
    check("latency_at", key_state, 32'hFF);
    check("all_press_pulse", press_pulse, 32'hFF);
    tick(5);
    check("fill_count", ev_count, 32'd4);
    check("fill_head", ev_code, 32'h8);
    expect_events("press_order", 32'hFEDCBA98, 8);
    keys = 8'h00;
    expect_events("release_order", 32'h76543210, 8);

    // 2: short glitch
    keys = 8'h04;
    tick(3);
    keys = 8'h00;
    tick(12);
    check("glitch_state", key_state, 32'h00);
    check("glitch_valid", ev_valid, 32'h0);

    // 3: single key press
    keys = 8'h20;
    tick(6);
    check("k5_state", key_state, 32'h20);
    check("k5_pulse", press_pulse, 32'h20);
    tick(1);
    check("k5_pulse_end", press_pulse, 32'h00);
    expect_events("k5_event", 32'hD, 1);
    check("k5_drained", {ev_valid, ev_count}, 32'h0);
    keys = 8'h00;
    expect_events("k5_release", 32'h5, 1);

    // 4: two keys together
    keys = 8'h81;
    expect_events("pair_press", 32'hF8, 2);
    keys = 8'h00;
    expect_events("pair_release", 32'h70, 2);

    // 5: fill, pending, duplicate loss, clear, drain
    ev_ready = 1'b0;
    keys = 8'h08; tick(8);
    keys = 8'h00; tick(8);
    keys = 8'h08; tick(8);
    keys = 8'h00; tick(8);
    check("full_count", ev_count, 32'd4);
    keys = 8'h08; tick(8);
    keys = 8'h00; tick(8);
    check("no_ovf_yet", overflow, 32'h0);
    keys = 8'h08; tick(8);
    check("ovf_set", overflow, 32'h1);
    overflow_clr = 1'b1; tick(1);
    overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 32'h0);
    expect_events("drain_order", 32'h003B3B3B, 6);
    check("drain_empty", ev_count, 32'd0);
    keys = 8'h00;
    expect_events("k3_release", 32'h3, 1);

    // 6: reset with queued and pending events
    keys = 8'h1F;
    tick(10);
    check("pre_reset_count", ev_count, 32'd3);
    rst = 1'b0;
    tick(1);
    check("mid_reset", {key_state, 4'(ev_valid), 4'(ev_count), 4'(overflow)}, 32'h0);
    keys = 8'h00;
    rst = 1'b1;
    tick(20);
    check("no_stale", {key_state, 4'(ev_valid), 4'(ev_count)}, 32'h0);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = int'($urandom_range(0, 7));
        keys[b] = ~keys[b];
      end
      if (((c / 200) % 2) == 0) ev_ready = ($urandom_range(0, 3) != 0);
      else                      ev_ready = ($urandom_range(0, 9) == 0);
      overflow_clr = ($urandom_range(0, 30) == 0);
      rst = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    rst = 1'b1;
    overflow_clr = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
